// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM pipeline ID-stage control: scoreboard entry, control state, match helper.
package arm_pipe_pkg;

  localparam int REG_W = 4;

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_r_en;
  } sb_entry_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    FLUSH   = 2'd2,
    MEMWAIT = 2'd3
  } ctrl_state_t;

  localparam sb_entry_t BUBBLE = '0;

  // rn is always compared; src2 only when the ID instruction actually reads it
  function automatic logic sb_match(input sb_entry_t s, input logic [REG_W-1:0] rn,
                                    input logic [REG_W-1:0] src2, input logic two_src);
    return s.wb_en & ((s.dest == rn) | (two_src & (s.dest == src2)));
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-slot (EX, MEM) destination scoreboard with RAW match against the ID-stage sources.
module hazard_scoreboard
  import arm_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             insert,
  input  sb_entry_t        entry,
  input  logic [REG_W-1:0] rn,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  output logic             ex_match,
  output logic             ex_load,
  output logic             mem_match
);

  sb_entry_t r_ex;
  sb_entry_t r_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex  <= BUBBLE;
      r_mem <= BUBBLE;
    end else if (advance) begin
      r_mem <= r_ex;
      r_ex  <= insert ? entry : BUBBLE;
    end
  end

  always_comb begin
    ex_match  = sb_match(r_ex, rn, src2, two_src);
    mem_match = sb_match(r_mem, rn, src2, two_src);
    ex_load   = r_ex.mem_r_en;
  end

endmodule

// File: rtl/id_hazard_controller.sv
// ID-stage hazard/flush/freeze controller with saturating stall counter.
// FORWARDING_EN: only load-use hazards against the EX slot stall.
module id_hazard_controller #(
  parameter int REG_W = arm_pipe_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             exe_branch_taken,
  input  logic             mem_ready,
  output logic             hazard,
  output logic             freeze_if,
  output logic             flush,
  output logic             freeze_all,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);

  arm_pipe_pkg::sb_entry_t   w_entry;
  arm_pipe_pkg::ctrl_state_t r_state;
  arm_pipe_pkg::ctrl_state_t w_next;
  logic                      w_ex_match;
  logic                      w_ex_load;
  logic                      w_mem_match;
  logic                      w_raw;
  logic [CNT_W-1:0]          r_cnt;

  assign w_entry = '{dest: id_dest, wb_en: id_wb_en, mem_r_en: id_mem_r_en};

  hazard_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .advance   (~freeze_all),
    .insert    (~(hazard | flush)),
    .entry     (w_entry),
    .rn        (id_rn),
    .src2      (id_src2),
    .two_src   (id_two_src),
    .ex_match  (w_ex_match),
    .ex_load   (w_ex_load),
    .mem_match (w_mem_match)
  );

`ifdef FORWARDING_EN
  assign w_raw = w_ex_match & w_ex_load;
`else
  // A load match is a subset of the EX match, so the interlock is unchanged
  assign w_raw = w_ex_match | w_mem_match | (w_ex_match & w_ex_load);
`endif

  always_comb begin
    flush      = exe_branch_taken;
    hazard     = w_raw & ~exe_branch_taken;
    freeze_if  = hazard;
    freeze_all = ~mem_ready;
    if (!mem_ready)            w_next = arm_pipe_pkg::MEMWAIT;
    else if (exe_branch_taken) w_next = arm_pipe_pkg::FLUSH;
    else if (w_raw)            w_next = arm_pipe_pkg::STALL;
    else                       w_next = arm_pipe_pkg::RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= arm_pipe_pkg::RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != arm_pipe_pkg::RUN && r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign state        = r_state;
  assign stall_cycles = r_cnt;

endmodule

// File: tb/tb_id_hazard_controller.sv
// Directed-vector scoreboard bench for id_hazard_controller; FORWARDING_EN selects the forwarding vectors.
module tb_id_hazard_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  id_rn = '0, id_src2 = '0, id_dest = '0;
  logic        id_two_src = 1'b0, id_wb_en = 1'b0, id_mem_r_en = 1'b0;
  logic        exe_branch_taken = 1'b0, mem_ready = 1'b1;
  logic        hazard, freeze_if, flush, freeze_all;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  int checks = 0;
  int failures = 0;
  int vec_id = 0;

  typedef struct {
    int          id;
    logic        chk;
    logic [21:0] v;
  } exp_t;
  exp_t q[$];

  localparam logic [1:0] RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2, MEMWAIT = 2'd3;

  id_hazard_controller #(.REG_W(4), .CNT_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rn            (id_rn),
    .id_src2          (id_src2),
    .id_two_src       (id_two_src),
    .id_wb_en         (id_wb_en),
    .id_mem_r_en      (id_mem_r_en),
    .id_dest          (id_dest),
    .exe_branch_taken (exe_branch_taken),
    .mem_ready        (mem_ready),
    .hazard           (hazard),
    .freeze_if        (freeze_if),
    .flush            (flush),
    .freeze_all       (freeze_all),
    .state            (state),
    .stall_cycles     (stall_cycles)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs after the rising edge and queue the outputs expected for that cycle
  task automatic step(input logic r, input logic [3:0] rn, input logic [3:0] src2, input logic two,
                      input logic wb, input logic ld, input logic [3:0] dest, input logic br,
                      input logic mr, input logic chk, input logic hz, input logic fl,
                      input logic fa, input logic [1:0] st, input logic [15:0] cnt);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r; id_rn = rn; id_src2 = src2; id_two_src = two; id_wb_en = wb;
    id_mem_r_en = ld; id_dest = dest; exe_branch_taken = br; mem_ready = mr;
    e.id  = vec_id;
    e.chk = chk;
    e.v   = {hz, hz, fl, fa, st, cnt};
    q.push_back(e);
    vec_id++;
  endtask

  initial begin : monitor
    exp_t e;
    logic [21:0] act;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e   = q.pop_front();
        act = {hazard, freeze_if, flush, freeze_all, state, stall_cycles};
        if (e.chk) begin
          checks++;
          if (act !== e.v) begin
            failures++;
            $display("FAIL vec%0d {hz,fi,fl,fa,st,cnt} got=%h exp=%h", e.id, act, e.v);
          end
        end
      end
    end
  end

  initial begin : driver
    //   rst rn src2 two wb ld dest br mr  chk hz fl fa st       cnt
    step(1, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, RUN,     0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 1, RUN,     0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, RUN,     0);
`ifdef FORWARDING_EN
    step(0, 0, 0, 0, 1, 1, 3, 0, 1,  1, 0, 0, 0, RUN,     0);
    step(0, 3, 0, 0, 1, 0, 4, 0, 1,  1, 1, 0, 0, RUN,     0);
    step(0, 3, 0, 0, 1, 0, 4, 0, 1,  1, 0, 0, 0, STALL,   1);
    step(0, 4, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, RUN,     1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, RUN,     1);
`else
    // producer r1, consumer rn=1: two stall cycles
    step(0, 5, 0, 0, 1, 0, 1, 0, 1,  1, 0, 0, 0, RUN,     0);
    step(0, 1, 0, 0, 1, 0, 6, 0, 1,  1, 1, 0, 0, RUN,     0);
    step(0, 1, 0, 0, 1, 0, 6, 0, 1,  1, 1, 0, 0, STALL,   1);
    step(0, 1, 0, 0, 1, 0, 6, 0, 1,  1, 0, 0, 0, STALL,   2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, RUN,     2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, RUN,     2);
    // producer r2, unrelated, consumer src2=2: one stall cycle
    step(0, 0, 0, 0, 1, 0, 2, 0, 1,  1, 0, 0, 0, RUN,     2);
    step(0, 8, 0, 0, 1, 0, 7, 0, 1,  1, 0, 0, 0, RUN,     2);
    step(0, 9, 2, 1, 1, 0,10, 0, 1,  1, 1, 0, 0, RUN,     2);
    step(0, 9, 2, 1, 1, 0,10, 0, 1,  1, 0, 0, 0, STALL,   3);
    // same sequence with two_src=0: no stall
    step(0, 0, 0, 0, 1, 0, 2, 0, 1,  1, 0, 0, 0, RUN,     3);
    step(0, 8, 0, 0, 1, 0, 7, 0, 1,  1, 0, 0, 0, RUN,     3);
    step(0, 9, 2, 0, 1, 0,10, 0, 1,  1, 0, 0, 0, RUN,     3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, RUN,     3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, RUN,     3);
    // branch over a pending hazard: flush, no stall, EX gets a bubble
    step(0, 0, 0, 0, 1, 0, 3, 0, 1,  1, 0, 0, 0, RUN,     3);
    step(0, 3, 0, 0, 1, 0, 4, 1, 1,  1, 0, 1, 0, RUN,     3);
    step(0, 4, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, FLUSH,   4);
    // memory wait with producer r5 in EX, reader of r5 in ID
    step(0, 0, 0, 0, 1, 0, 5, 0, 1,  1, 0, 0, 0, RUN,     4);
    step(0, 5, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, RUN,     4);
    step(0, 5, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, MEMWAIT, 5);
    step(0, 5, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, MEMWAIT, 6);
    step(0, 5, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, MEMWAIT, 7);
    step(0, 5, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, STALL,   8);
    step(0, 5, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, STALL,   9);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, RUN,     9);
    // drive the counter into saturation with a long memory wait
    for (int k = 0; k < 65530; k++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, (k < 2), 0, 0, 1,
           (k == 0) ? RUN : MEMWAIT, 16'(9 + k));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, MEMWAIT, 16'hFFFF);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, MEMWAIT, 16'hFFFF);
    step(0, 0, 0, 0, 1, 0, 1, 0, 1,  1, 0, 0, 0, MEMWAIT, 16'hFFFF);
    step(0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, RUN,     16'hFFFF);
    step(0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, STALL,   16'hFFFF);
    // asynchronous reset in the middle of the stall
    step(1, 1, 0, 0, 0, 0, 0, 1, 1,  1, 0, 1, 0, RUN,     0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, RUN,     0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, RUN,     0);
`endif
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
